// File: rtl/mtr_pwm_decode.sv
// mtr_pwm_decode: receive side of the motor PWM link. Recovers the signed
// 11-bit speed command of each motor from the PWM1 high time, reports
// malformed periods, and latches a sticky shoot-through flag when both legs
// of an H-bridge pair are high in the same cycle.

// One decode channel: measures period and high time of a registered PWM1
// stream and converts the high time into a two's complement speed.
module mtr_pwm_chan #(
    parameter int PERIOD = 2048,
    parameter int TMO    = 2100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm,       // registered PWM1 level
    input  logic        rise,      // registered PWM1 rising edge
    output logic [10:0] spd,
    output logic        vld,
    output logic        per_err
);
    localparam int          STAGES   = 2;
    localparam logic [11:0] PER_CNT  = 12'(PERIOD);
    // Timeout fires on the cycle the period counter would reach TMO, so a
    // static input produces one update exactly every TMO cycles.
    localparam logic [11:0] TMO_LAST = 12'(TMO - 1);
    localparam logic [10:0] MID      = 11'h400;
    localparam logic [10:0] HMAX     = 11'h7FF;
    localparam logic [10:0] FULL     = 11'h3FF;

    typedef enum logic {WAIT, MEAS} state_t;

    state_t             state, state_nxt;
    logic [11:0]        pcnt, pcnt_nxt;
    logic [10:0]        hcnt, hcnt_nxt;
    logic               upd, err;
    logic [10:0]        res, res_q;
    logic [STAGES:1]    vld_pipe, err_pipe;

    // Measurement state and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT;
            pcnt  <= '0;
            hcnt  <= '0;
        end else begin
            state <= state_nxt;
            pcnt  <= pcnt_nxt;
            hcnt  <= hcnt_nxt;
        end
    end

    // Next-state logic: a rising edge always wins over a coincident timeout;
    // only an edge seen in MEAS closes a measured period.
    always_comb begin
        state_nxt = state;
        pcnt_nxt  = pcnt + 12'd1;
        hcnt_nxt  = hcnt;
        upd       = 1'b0;
        err       = 1'b0;
        res       = MID;
        if (rise) begin
            state_nxt = MEAS;
            pcnt_nxt  = 12'd1;
            hcnt_nxt  = 11'd1;
            if (state == MEAS) begin
                if (pcnt == PER_CNT) begin
                    upd = 1'b1;
                    res = hcnt - MID;
                end else begin
                    err = 1'b1;
                end
            end
        end else if (pcnt == TMO_LAST) begin
            // Static line: report full reverse or full forward.
            state_nxt = WAIT;
            pcnt_nxt  = '0;
            upd       = 1'b1;
            res       = pwm ? FULL : MID;
        end else if (state == MEAS && pwm && hcnt != HMAX) begin
            hcnt_nxt = hcnt + 11'd1;
        end
    end

    // Two-stage result pipeline; the update becomes visible together with vld.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            err_pipe <= '0;
            res_q    <= '0;
            spd      <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], upd};
            err_pipe <= {err_pipe[STAGES-1:1], err};
            if (upd)
                res_q <= res;
            if (vld_pipe[1])
                spd <= res_q;
        end
    end

    assign vld     = vld_pipe[STAGES];
    assign per_err = err_pipe[STAGES];
endmodule

// Top: input registration, two independent channels, shoot-through flag.
module mtr_pwm_decode #(
    parameter int PERIOD = 2048,
    parameter int TMO    = 2100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lftPWM1,
    input  logic        lftPWM2,
    input  logic        rghtPWM1,
    input  logic        rghtPWM2,
    input  logic        clr_flt,
    output logic [10:0] lft_spd,
    output logic [10:0] rght_spd,
    output logic        lft_vld,
    output logic        rght_vld,
    output logic        per_err,
    output logic        shoot_thru
);
    localparam int NUM_CH = 2;   // index 0 = left, 1 = right

    logic [NUM_CH-1:0]       pwm1_r, pwm1_d, pwm2_r;
    logic [NUM_CH-1:0]       rise, vld_ch, err_ch;
    logic [NUM_CH-1:0][10:0] spd_ch;

    // Single registration stage; inputs share this clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm1_r <= '0;
            pwm1_d <= '0;
            pwm2_r <= '0;
        end else begin
            pwm1_r <= {rghtPWM1, lftPWM1};
            pwm2_r <= {rghtPWM2, lftPWM2};
            pwm1_d <= pwm1_r;
        end
    end

    assign rise = pwm1_r & ~pwm1_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mtr_pwm_chan #(
            .PERIOD (PERIOD),
            .TMO    (TMO)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .pwm     (pwm1_r[g]),
            .rise    (rise[g]),
            .spd     (spd_ch[g]),
            .vld     (vld_ch[g]),
            .per_err (err_ch[g])
        );
    end

    // Sticky overlap flag; a live overlap beats a clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            shoot_thru <= 1'b0;
        else if (|(pwm1_r & pwm2_r))
            shoot_thru <= 1'b1;
        else if (clr_flt)
            shoot_thru <= 1'b0;
    end

    assign lft_spd  = spd_ch[0];
    assign rght_spd = spd_ch[1];
    assign lft_vld  = vld_ch[0];
    assign rght_vld = vld_ch[1];
    assign per_err  = |err_ch;
endmodule

// File: tb/tb_mtr_pwm_decode.sv
// Bench for mtr_pwm_decode: drives PWM waveforms sample by sample and
// predicts outputs from rise times and cumulative high-sample counts.
module tb_mtr_pwm_decode;
    localparam int PERIOD = 2048;
    localparam int TMO    = 2100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lftPWM1 = 1'b0, lftPWM2 = 1'b0, rghtPWM1 = 1'b0, rghtPWM2 = 1'b0;
    logic        clr_flt = 1'b0;
    logic [10:0] lft_spd, rght_spd;
    logic        lft_vld, rght_vld, per_err, shoot_thru;

    int checks = 0;
    int errors = 0;
    int e = 0;          // posedges seen so far
    int nv_l = 0;       // left vld pulses observed
    int ne = 0;         // per_err pulses observed

    // Reference model state, per channel (0 = left, 1 = right).
    int          cum[2];        // high samples since reset
    int          rise_cum[2];   // cum at the last rising sample
    int          last_rise[2];  // sample index of the last rise
    int          deadline[2];   // edge at which a timeout is due
    bit          prev[2];
    bit          armed[2];      // a rise has been seen since the last timeout/reset
    logic [10:0] m_spd[2];
    logic [10:0] exp_l[int];
    logic [10:0] exp_r[int];
    bit          exp_e[int];
    bit          m_shoot = 1'b0;
    bit          ov_prev = 1'b0;

    mtr_pwm_decode #(.PERIOD(PERIOD), .TMO(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .lftPWM1    (lftPWM1),
        .lftPWM2    (lftPWM2),
        .rghtPWM1   (rghtPWM1),
        .rghtPWM2   (rghtPWM2),
        .clr_flt    (clr_flt),
        .lft_spd    (lft_spd),
        .rght_spd   (rght_spd),
        .lft_vld    (lft_vld),
        .rght_vld   (rght_vld),
        .per_err    (per_err),
        .shoot_thru (shoot_thru)
    );

    always #5 clk = ~clk;

    // Edge counter.
    always @(posedge clk) e <= e + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int f);
        for (int c = 0; c < 2; c++) begin
            cum[c] = 0; rise_cum[c] = 0; last_rise[c] = 0;
            prev[c] = 1'b0; armed[c] = 1'b0; m_spd[c] = '0;
            deadline[c] = f + TMO - 1;
        end
        exp_l.delete(); exp_r.delete(); exp_e.delete();
        m_shoot = 1'b0; ov_prev = 1'b0;
    endtask

    task automatic sched(input int c, input int ed, input logic [10:0] v);
        if (c == 0) exp_l[ed] = v;
        else        exp_r[ed] = v;
    endtask

    // Sample n is registered at edge n, acted on at edge n+1, visible after n+2.
    task automatic model_sample(input int c, input bit s, input int n);
        int len, hi;
        if (s && !prev[c]) begin
            if (armed[c]) begin
                len = n - last_rise[c];
                hi  = cum[c] - rise_cum[c];
                if (hi > 2047) hi = 2047;
                if (len == PERIOD) sched(c, n + 2, 11'(hi - 1024));
                else               exp_e[n + 2] = 1'b1;
            end
            armed[c]     = 1'b1;
            last_rise[c] = n;
            rise_cum[c]  = cum[c];
            deadline[c]  = n + TMO;
        end else if (n + 1 == deadline[c]) begin
            sched(c, n + 2, s ? 11'h3FF : 11'h400);
            armed[c]    = 1'b0;
            deadline[c] = deadline[c] + TMO;
        end
        cum[c]  = cum[c] + (s ? 1 : 0);
        prev[c] = s;
    endtask

    task automatic check_outputs();
        bit vl, vr, ve;
        vl = exp_l.exists(e);
        if (vl) begin m_spd[0] = exp_l[e]; exp_l.delete(e); end
        vr = exp_r.exists(e);
        if (vr) begin m_spd[1] = exp_r[e]; exp_r.delete(e); end
        ve = exp_e.exists(e);
        if (ve) exp_e.delete(e);
        if (lft_vld === 1'b1) nv_l++;
        if (per_err === 1'b1) ne++;
        chk("lft_vld",    32'(lft_vld),    32'(vl));
        chk("rght_vld",   32'(rght_vld),   32'(vr));
        chk("per_err",    32'(per_err),    32'(ve));
        chk("lft_spd",    32'(lft_spd),    32'(m_spd[0]));
        chk("rght_spd",   32'(rght_spd),   32'(m_spd[1]));
        chk("shoot_thru", 32'(shoot_thru), 32'(m_shoot));
    endtask

    // One clock: drive at negedge, advance the model, check after the edge.
    task automatic tick(input bit l1, input bit l2, input bit r1, input bit r2, input bit clr);
        int n;
        lftPWM1 = l1; lftPWM2 = l2; rghtPWM1 = r1; rghtPWM2 = r2; clr_flt = clr;
        n = e + 1;
        model_sample(0, l1, n);
        model_sample(1, r1, n);
        m_shoot = ov_prev | (m_shoot & ~clr);
        ov_prev = (l1 & l2) | (r1 & r2);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // hl/hr = high samples per period; 0 holds low, len holds high.
    task automatic periods(input int nper, input int len, input int hl, input int hr);
        bit a, b;
        for (int p = 0; p < nper; p++)
            for (int i = 0; i < len; i++) begin
                a = (i < hl);
                b = (i < hr);
                tick(a, ~a, b, ~b, 1'b0);
            end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_lspd",  32'(lft_spd),    32'd0);
        chk("rst_rspd",  32'(rght_spd),   32'd0);
        chk("rst_lvld",  32'(lft_vld),    32'd0);
        chk("rst_rvld",  32'(rght_vld),   32'd0);
        chk("rst_perr",  32'(per_err),    32'd0);
        chk("rst_shoot", 32'(shoot_thru), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset(e + 1);
        nv_l = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        do_reset();

        // Mid-scale duty: zero speed, vld from the second period on.
        periods(4, PERIOD, 'h400, 'h400);
        chk("t1_nvld", 32'(nv_l), 32'd3);
        chk("t1_lspd", 32'(lft_spd), 32'h000);
        chk("t1_rspd", 32'(rght_spd), 32'h000);

        // Asymmetric duties.
        periods(3, PERIOD, 'h600, 'h100);
        chk("t2_lspd", 32'(lft_spd), 32'h200);
        chk("t2_rspd", 32'(rght_spd), 32'h500);

        // Left static low, then static high; right keeps running.
        for (int p = 0; p < 4; p++) periods(1, PERIOD, 0, int'($urandom_range(1, 2047)));
        chk("tmo_low", 32'(lft_spd), 32'h400);
        for (int p = 0; p < 4; p++) periods(1, PERIOD, PERIOD, int'($urandom_range(1, 2047)));
        chk("tmo_high", 32'(lft_spd), 32'h3FF);

        // Shoot-through: set, clear, set-wins-over-clear.
        tick(0, 1, 0, 1, 0);
        tick(1, 1, 0, 1, 0);
        repeat (3) tick(0, 1, 0, 1, 0);
        chk("st_set", 32'(shoot_thru), 32'd1);
        tick(0, 1, 0, 1, 1);
        tick(0, 1, 0, 1, 0);
        chk("st_clr", 32'(shoot_thru), 32'd0);
        tick(0, 1, 1, 1, 0);
        tick(0, 1, 1, 1, 1);
        tick(0, 1, 1, 1, 1);
        chk("st_hold", 32'(shoot_thru), 32'd1);
        tick(0, 1, 0, 1, 1);
        tick(0, 1, 0, 1, 1);
        chk("st_clr2", 32'(shoot_thru), 32'd0);

        // Stretched period: one per_err, speed held, next good period updates.
        periods(2, PERIOD, 'h500, 'h500);
        ne = 0;
        periods(1, PERIOD + 2, 'h300, 'h300);
        periods(1, PERIOD, 'h600, 'h600);
        periods(1, PERIOD, 'h100, 'h100);
        chk("str_nerr", 32'(ne), 32'd1);
        chk("str_lspd", 32'(lft_spd), 32'h200);

        // Random duties with occasional period jitter.
        for (int p = 0; p < 6; p++) begin
            int len;
            len = PERIOD + ($urandom_range(0, 3) == 0 ? int'($urandom_range(0, 2)) - 1 : 0);
            periods(1, len, int'($urandom_range(1, 2047)), int'($urandom_range(1, 2047)));
        end

        // Reset in mid-period at duty 0x700.
        periods(1, PERIOD, 'h700, 'h700);
        periods(1, 1000, 'h700, 'h700);
        do_reset();
        periods(3, PERIOD, 'h700, 'h700);
        chk("rst_nvld", 32'(nv_l), 32'd2);
        chk("rst2_lspd", 32'(lft_spd), 32'h300);
        chk("rst2_rspd", 32'(rght_spd), 32'h300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
